// File: rtl/div_issue_queue.sv
// div_issue_queue: request FIFO and single-issue controller in front of the serial divider.
// Only one result is ever outstanding, so the divider's unstallable output pulse is never lost.
module div_issue_queue #(
   parameter int WIDTH = 64,
   parameter int TAG_W = 6,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [WIDTH-1:0] req_a,
   input  logic [WIDTH-1:0] req_b,
   input  logic [1:0]       req_op,
   input  logic [TAG_W-1:0] req_tag,
   output logic [WIDTH-1:0] div_input1,
   output logic [WIDTH-1:0] div_input2,
   output logic [1:0]       div_operation,
   output logic             div_input_valid,
   output logic             div_flush,
   input  logic             div_ready,
   input  logic             div_output_valid,
   input  logic [WIDTH-1:0] div_result,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_result,
   output logic [TAG_W-1:0] rsp_tag,
   output logic             rsp_div_zero
);
   localparam int AW = $clog2(DEPTH);
   typedef enum logic {IDLE, BUSY} state_t;
   state_t state, state_nxt;
   logic [WIDTH-1:0] mem_a [DEPTH];
   logic [WIDTH-1:0] mem_b [DEPTH];
   logic [1:0]       mem_op [DEPTH];
   logic [TAG_W-1:0] mem_tag [DEPTH];
   logic             mem_z [DEPTH];
   logic [AW:0]      wr_ptr, rd_ptr;
   logic [TAG_W-1:0] fl_tag;
   logic             fl_zero;
   logic             full, empty, push;
   assign empty = wr_ptr == rd_ptr;
   assign full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign req_ready = !full && !flush;
   assign push = req_valid && req_ready;
   assign div_flush = flush;
   assign div_input1 = mem_a[rd_ptr[AW-1:0]];
   assign div_input2 = mem_b[rd_ptr[AW-1:0]];
   assign div_operation = mem_op[rd_ptr[AW-1:0]];
   // holding off issue while a response waits keeps div_output_valid from ever colliding with rsp_valid
   always_comb begin
      div_input_valid = (state == IDLE) && !empty && div_ready && !rsp_valid && !flush;
      state_nxt = flush ? IDLE : (state == IDLE) ? (div_input_valid ? BUSY : IDLE) : (div_output_valid ? IDLE : BUSY);
   end
   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else state <= state_nxt;
   end
   always_ff @(posedge clk) begin
      if (push) begin
         mem_a[wr_ptr[AW-1:0]] <= req_a;
         mem_b[wr_ptr[AW-1:0]] <= req_b;
         mem_op[wr_ptr[AW-1:0]] <= req_op;
         mem_tag[wr_ptr[AW-1:0]] <= req_tag;
         mem_z[wr_ptr[AW-1:0]] <= req_b == '0;
      end
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         fl_tag <= '0;
         fl_zero <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_result <= '0;
         rsp_tag <= '0;
         rsp_div_zero <= 1'b0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         rsp_valid <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (div_input_valid) begin
            rd_ptr <= rd_ptr + 1'b1;
            fl_tag <= mem_tag[rd_ptr[AW-1:0]];
            fl_zero <= mem_z[rd_ptr[AW-1:0]];
         end
         if (state == BUSY && div_output_valid) begin
            rsp_valid <= 1'b1;
            rsp_result <= div_result;
            rsp_tag <= fl_tag;
            rsp_div_zero <= fl_zero;
         end else if (rsp_ready) rsp_valid <= 1'b0;
      end
   end
endmodule
